// File: rtl/btb_pkg.sv
// Shared types and helpers for the direct-mapped branch target buffer.
// The statistics counters are built only when BTB_STATS_EN is defined.
package btb_pkg;

  localparam int BTB_N     = 128;
  localparam int BTB_IDX_W = $clog2(BTB_N);
  localparam int BTB_TAG_W = 32 - BTB_IDX_W - 2;

  typedef struct packed {
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } btb_state_e;

  function automatic logic [BTB_IDX_W-1:0] btb_idx(input logic [31:0] pc);
    return pc[BTB_IDX_W+1:2];
  endfunction

  function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [31:0] pc);
    return pc[31:BTB_IDX_W+2];
  endfunction

endpackage

// File: rtl/btb_flush_ctrl.sv
// Invalidation sweep controller: walks every BTB index once after a flush
// request, clearing one valid bit per cycle.
module btb_flush_ctrl
  import btb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  output logic                 sweep_active,
  output logic [BTB_IDX_W-1:0] sweep_idx,
  output logic                 sweep_clr
);

  btb_state_e           r_state;
  logic [BTB_IDX_W-1:0] r_cnt;

  // Flush requests arriving mid-sweep are ignored; the counter wraps to 0 on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
          end
        end
        SWEEP: begin
          r_cnt <= r_cnt + BTB_IDX_W'(1);
          if (r_cnt == BTB_IDX_W'(BTB_N - 1)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sweep_active = (r_state == SWEEP);
  assign sweep_idx    = r_cnt;
  assign sweep_clr    = sweep_active;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup for fetch, training from execute,
// flush sweep via btb_flush_ctrl. Optional counters under BTB_STATS_EN.
module branch_target_buffer
  import btb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  input  logic        is_branch_if,
  output logic [31:0] predicted_pc,
  output logic        btb_hit,
  input  logic        is_branch_ex,
  input  logic [31:0] pc_ex,
  input  logic [31:0] branch_pc_ex,
  input  logic        flush,
  output logic        flush_busy,
  output logic [31:0] lookup_cnt,
  output logic [31:0] hit_cnt
);

  btb_entry_t           r_entry [BTB_N];
  logic [BTB_N-1:0]     r_valid;

  logic                 w_sweep_active;
  logic [BTB_IDX_W-1:0] w_sweep_idx;
  logic                 w_sweep_clr;
  logic [BTB_IDX_W-1:0] w_if_idx;
  logic [BTB_IDX_W-1:0] w_ex_idx;
  btb_entry_t           w_if_entry;
  logic                 w_unused_pc;

  btb_flush_ctrl u_flush_ctrl (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .sweep_active (w_sweep_active),
    .sweep_idx    (w_sweep_idx),
    .sweep_clr    (w_sweep_clr)
  );

  assign w_if_idx    = btb_idx(pc_if);
  assign w_ex_idx    = btb_idx(pc_ex);
  assign w_if_entry  = r_entry[w_if_idx];
  assign w_unused_pc = ^{pc_if[1:0], pc_ex[1:0]};

  // Training is frozen during a sweep so no entry can be revalidated behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) begin
        r_entry[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (is_branch_ex && !w_sweep_active) begin
        r_entry[w_ex_idx] <= '{tag: btb_tag(pc_ex), target: branch_pc_ex};
        r_valid[w_ex_idx] <= 1'b1;
      end
      if (w_sweep_clr) begin
        r_valid[w_sweep_idx] <= 1'b0;
      end
    end
  end

  assign predicted_pc = w_if_entry.target;
  assign btb_hit      = r_valid[w_if_idx] && (w_if_entry.tag == btb_tag(pc_if)) && !w_sweep_active;
  assign flush_busy   = w_sweep_active;

`ifdef BTB_STATS_EN
  logic [31:0] r_lookup_cnt;
  logic [31:0] r_hit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lookup_cnt <= '0;
      r_hit_cnt    <= '0;
    end else begin
      if (is_branch_if && (r_lookup_cnt != 32'hFFFF_FFFF)) begin
        r_lookup_cnt <= r_lookup_cnt + 32'd1;
      end
      if (is_branch_if && btb_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
    end
  end

  assign lookup_cnt = r_lookup_cnt;
  assign hit_cnt    = r_hit_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = is_branch_if;
  assign lookup_cnt     = '0;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_if = '0;
  logic        is_branch_if = 1'b0;
  logic [31:0] predicted_pc;
  logic        btb_hit;
  logic        is_branch_ex = 1'b0;
  logic [31:0] pc_ex = '0;
  logic [31:0] branch_pc_ex = '0;
  logic        flush = 1'b0;
  logic        flush_busy;
  logic [31:0] lookup_cnt;
  logic [31:0] hit_cnt;

  typedef struct {
    string       name;
    bit          chkPred;
    logic [31:0] pred;
    bit          chkHit;
    logic        hit;
    bit          chkBusy;
    logic        busy;
    bit          chkCnt;
    logic [31:0] lookups;
    logic [31:0] hits;
  } expect_t;

  expect_t sb[$];
  int      assertCount = 0;
  int      failCount   = 0;

`ifdef BTB_STATS_EN
  localparam logic [31:0] EXP_LOOKUPS = 32'd10;
  localparam logic [31:0] EXP_HITS    = 32'd6;
`else
  localparam logic [31:0] EXP_LOOKUPS = 32'd0;
  localparam logic [31:0] EXP_HITS    = 32'd0;
`endif

  branch_target_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .pc_if        (pc_if),
    .is_branch_if (is_branch_if),
    .predicted_pc (predicted_pc),
    .btb_hit      (btb_hit),
    .is_branch_ex (is_branch_ex),
    .pc_ex        (pc_ex),
    .branch_pc_ex (branch_pc_ex),
    .flush        (flush),
    .flush_busy   (flush_busy),
    .lookup_cnt   (lookup_cnt),
    .hit_cnt      (hit_cnt)
  );

  always #5 clk = ~clk;

  function automatic expect_t mkExp(string name, bit cp, logic [31:0] p, bit ch, logic h, bit cb, logic b);
    expect_t e;
    e.name = name; e.chkPred = cp; e.pred = p; e.chkHit = ch; e.hit = h;
    e.chkBusy = cb; e.busy = b; e.chkCnt = 1'b0; e.lookups = '0; e.hits = '0;
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic [31:0] pcIf, input logic brIf,
                               input logic brEx, input logic [31:0] pcEx, input logic [31:0] tgt,
                               input logic fl, input expect_t e);
    @(posedge clk);
    #1;
    rst = r; pc_if = pcIf; is_branch_if = brIf;
    is_branch_ex = brEx; pc_ex = pcEx; branch_pc_ex = tgt; flush = fl;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      expect_t e;
      e = sb.pop_front();
      if (e.chkPred) checkOutput({e.name, ".predicted_pc"}, predicted_pc, e.pred);
      if (e.chkHit)  checkOutput({e.name, ".btb_hit"}, {31'd0, btb_hit}, {31'd0, e.hit});
      if (e.chkBusy) checkOutput({e.name, ".flush_busy"}, {31'd0, flush_busy}, {31'd0, e.busy});
      if (e.chkCnt) begin
        checkOutput({e.name, ".lookup_cnt"}, lookup_cnt, e.lookups);
        checkOutput({e.name, ".hit_cnt"}, hit_cnt, e.hits);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expect_t e;
    logic [31:0] tgt;
    $display("[TB] starting branch_target_buffer bench");

    applyStimulus(1, 32'h40, 1, 0, 0, 0, 0, mkExp("reset0", 1, 0, 1, 0, 1, 0));
    applyStimulus(1, 32'h40, 1, 0, 0, 0, 0, mkExp("reset1", 1, 0, 1, 0, 1, 0));

    // Basic train/lookup and same-cycle read of old contents.
    applyStimulus(0, 32'h40, 1, 1, 32'h40, 32'h1000, 0, mkExp("sameCycle", 1, 0, 1, 0, 1, 0));
    applyStimulus(0, 32'h40, 1, 0, 0, 0, 0, mkExp("hit40", 1, 32'h1000, 1, 1, 1, 0));
    applyStimulus(0, 32'h240, 1, 1, 32'h240, 32'h2000, 0, mkExp("alias240", 1, 32'h1000, 1, 0, 0, 0));
    applyStimulus(0, 32'h40, 1, 0, 0, 0, 0, mkExp("alias40", 1, 32'h2000, 1, 0, 0, 0));
    applyStimulus(0, 32'h240, 1, 0, 0, 0, 0, mkExp("hit240", 1, 32'h2000, 1, 1, 0, 0));

    for (int i = 0; i < 128; i++) begin
      applyStimulus(0, 0, 0, 1, i * 4, 32'h8000_0000 + i * 16, 0, mkExp("fill", 0, 0, 0, 0, 0, 0));
    end
    applyStimulus(0, 32'h14, 1, 0, 0, 0, 0, mkExp("fillHit5", 1, 32'h8000_0050, 1, 1, 1, 0));
    applyStimulus(0, 32'h1FC, 1, 0, 0, 0, 0, mkExp("fillHit127", 1, 32'h8000_07F0, 1, 1, 1, 0));

    // Flush with a simultaneous write to index 7, then sweep with dropped writes.
    applyStimulus(0, 32'h14, 1, 1, 32'h21C, 32'hABC0, 1, mkExp("flushCycle", 1, 32'h8000_0050, 1, 1, 1, 0));
    for (int j = 0; j < 128; j++) begin
      tgt = (j == 7) ? 32'hABC0 : 32'h8000_0000 + j * 16;
      applyStimulus(0, j * 4, 1, 1, 32'h400 + j * 4, 32'hDEAD_0000, (j == 50),
                    mkExp("sweep", 1, tgt, 1, 0, 1, 1));
    end
    applyStimulus(0, 32'h14, 1, 0, 0, 0, 0, mkExp("postSweep14", 1, 32'h8000_0050, 1, 0, 1, 0));
    applyStimulus(0, 32'h400, 1, 0, 0, 0, 0, mkExp("droppedWr", 1, 32'h8000_0000, 1, 0, 1, 0));
    applyStimulus(0, 32'h21C, 1, 0, 0, 0, 0, mkExp("sweptWr", 1, 32'hABC0, 1, 0, 1, 0));

    // Second sweep interrupted by reset.
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 1, mkExp("flush2", 0, 0, 0, 0, 1, 0));
    for (int j = 0; j < 40; j++) begin
      applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, mkExp("sweep2", 1, 32'h8000_0100, 1, 0, 1, 1));
    end
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, mkExp("rstMidSweep", 1, 0, 1, 0, 1, 0));
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, mkExp("afterRst", 1, 0, 1, 0, 1, 0));

    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 0, 1, 32'h100 + k * 4, 32'h3000 + k, 0, mkExp("statsFill", 0, 0, 0, 0, 0, 0));
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 32'h100 + k * 4, 1, 0, 0, 0, 0, mkExp("statsHit", 1, 32'h3000 + k, 1, 1, 1, 0));
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 32'h500 + k * 4, 1, 0, 0, 0, 0, mkExp("statsMiss", 1, 32'h3000 + k, 1, 0, 1, 0));
    end
    e = mkExp("stats", 0, 0, 0, 0, 0, 0);
    e.chkCnt = 1'b1; e.lookups = EXP_LOOKUPS; e.hits = EXP_HITS;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, e);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer for the fetch stage of the pipelined core. Looks up the fetch PC each cycle and supplies the predicted target and a tag-qualified hit flag. Trains from resolved branches in execute. Provides a multi-cycle invalidation sweep for pipeline-wide flushes such as `fence.i`.

## Interface
- `N`, 128: number of entries, power of two.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_if`  in  32  fetch-stage PC.
- `is_branch_if`  in  1  fetch instruction is a branch; qualifies the lookup.
- `predicted_pc`  out  32  stored target at `pc_if[n+1:2]`, where `n = log2(N)`.
- `btb_hit`  out  1  the indexed entry is valid, its tag equals `pc_if[31:n+2]`, and no sweep is active.
- `is_branch_ex`  in  1  a branch resolved in execute; write enable.
- `pc_ex`  in  32  PC of the resolved branch.
- `branch_pc_ex`  in  32  resolved target to store.
- `flush`  in  1  single-cycle pulse that requests a full invalidation.
- `flush_busy`  out  1  an invalidation sweep is in progress.
- `lookup_cnt`  out  32  number of qualified lookups; macro-dependent.
- `hit_cnt`  out  32  number of qualified lookups that hit; macro-dependent.

## Operation
- **Storage:** per entry, a target (32 bits), a tag (`32-n-2` bits) and a valid bit. Index is `pc[n+1:2]`; the tag is `pc[31:n+2]`.
- **Reset:** all targets, tags and valid bits go to 0. Counters go to 0. FSM goes to IDLE. Outputs: `predicted_pc=0`, `btb_hit=0`, `flush_busy=0`.
- **Lookup:**
  - `predicted_pc` is the raw target array value at the index. It is not qualified by tag, valid, or sweep state.
  - `btb_hit` is tag-qualified as defined in the port list.
- **Update:** when `is_branch_ex=1` and the FSM is IDLE, write the target and tag at index `pc_ex[n+1:2]` and set valid. A new write overwrites any aliasing entry.
- **Flush FSM, two states:**
  - IDLE → SWEEP when `flush=1`. The sweep counter loads 0.
  - SWEEP: clear `valid[cnt]` and increment `cnt` every cycle. Targets and tags are untouched.
  - SWEEP → IDLE after clearing entry N-1. The sweep lasts exactly N cycles.
  - `flush` is ignored while in SWEEP.
  - `is_branch_ex` writes are dropped while in SWEEP.
- `flush_busy = (state == SWEEP)`.
- The counter is `n` bits wide and wraps naturally at N-1 → 0 on the exit cycle.

## Timing
- Lookup is combinational from registered state, so it has zero-cycle latency.
- An update is visible to lookups from the cycle after its rising edge.
- A read and a write to the same index in the same cycle: the read returns the old contents. There is no bypass.
- `flush` in IDLE: `flush_busy` rises on the next edge and stays high for N cycles. `btb_hit` is 0 from that edge onward.
- A write in the same cycle as `flush` (FSM in IDLE): the write is committed, then swept when the sweep reaches its index.
- `rst` during SWEEP: immediate return to IDLE with all state cleared.

## Configuration
- `BTB_STATS_EN` defined:
  - `lookup_cnt` increments on each cycle with `is_branch_if=1`.
  - `hit_cnt` increments when additionally `btb_hit=1`.
  - Both saturate at `32'hFFFF_FFFF` and are cleared only by `rst`.
- `BTB_STATS_EN` undefined: no counter registers; `lookup_cnt` and `hit_cnt` are tied to 0. The port list is identical in both builds.

## Structure
- `btb_pkg` holds:
  - constants `BTB_N`, `BTB_IDX_W`, `BTB_TAG_W`;
  - functions `btb_idx(pc)` and `btb_tag(pc)`;
  - the `btb_entry_t` struct {tag, target};
  - the FSM enum `btb_state_e` {IDLE, SWEEP}.
- Sub-module `btb_flush_ctrl` contains the FSM and sweep counter. It outputs `sweep_active`, `sweep_idx` and `sweep_clr`.

## Test plan
- Reset, then lookup `pc_if=0x0000_0040` with `is_branch_if=1` → `predicted_pc=0`, `btb_hit=0`.
- Update `pc_ex=0x0000_0040`, `branch_pc_ex=0x0000_1000`. Next cycle, lookup `0x40` → `predicted_pc=0x1000`, `btb_hit=1`. Same-cycle lookup → old value 0.
- Alias test:
  - Update `0x40` → `0x1000`, then look up `0x240` (same index, different tag) → `predicted_pc=0x1000`, `btb_hit=0`.
  - Update `0x240` → `0x2000`, then look up `0x40` → `predicted_pc=0x2000`, `btb_hit=0`.
- Flush test:
  - Fill all 128 entries, then pulse `flush` → `flush_busy` high for exactly 128 cycles and every lookup misses.
  - Updates issued during the sweep are dropped, so a lookup after the sweep still misses.
- Assert `rst` at sweep cycle 40 → `flush_busy=0` immediately and all outputs take their reset values.
- Built with `BTB_STATS_EN`: 10 lookups, of which 6 hit → `lookup_cnt=10`, `hit_cnt=6`. Built without it → both read 0.
